seg7_reg32_display: RTL and testbench

SEG7_REG32_DISPLAY -- requirements
Module: seg7_reg32_display

---
 rtl/seg7_reg32_display_pkg.sv | 19 +
 rtl/seg7_defs.vh | 24 ++
 rtl/seg7_hex_decoder.sv | 36 +++
 rtl/seg7_reg32_display.sv | 92 +++++++++
 tb/tb_seg7_reg32_display.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/seg7_reg32_display_pkg.sv
// Purpose: shared constants and helpers for the 32-bit register display.
// Latency: n/a (constants and a pure combinational function).
// Backpressure: n/a.
package seg7_reg32_display_pkg;

  `include "seg7_defs.vh"

  // Index of the most significant nonzero nibble; 0 when the value is 0,
  // which keeps digit 0 lit under leading-zero blanking.
  function automatic logic [2:0] msnz_idx(input logic [31:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i*4 +: 4] != 4'h0) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_defs.vh
// Shared seven-segment constants: active-low hex glyphs {g,f,e,d,c,b,a},
// the all-off blank pattern and the all-anodes-off pattern.
// Included into seg7_reg32_display_pkg so every user sees one definition.
`ifndef SEG7_DEFS_VH
`define SEG7_DEFS_VH
localparam logic [6:0] SEG7_HEX_0 = 7'h40;
localparam logic [6:0] SEG7_HEX_1 = 7'h79;
localparam logic [6:0] SEG7_HEX_2 = 7'h24;
localparam logic [6:0] SEG7_HEX_3 = 7'h30;
localparam logic [6:0] SEG7_HEX_4 = 7'h19;
localparam logic [6:0] SEG7_HEX_5 = 7'h12;
localparam logic [6:0] SEG7_HEX_6 = 7'h02;
localparam logic [6:0] SEG7_HEX_7 = 7'h78;
localparam logic [6:0] SEG7_HEX_8 = 7'h00;
localparam logic [6:0] SEG7_HEX_9 = 7'h10;
localparam logic [6:0] SEG7_HEX_A = 7'h08;
localparam logic [6:0] SEG7_HEX_B = 7'h03;
localparam logic [6:0] SEG7_HEX_C = 7'h46;
localparam logic [6:0] SEG7_HEX_D = 7'h21;
localparam logic [6:0] SEG7_HEX_E = 7'h06;
localparam logic [6:0] SEG7_HEX_F = 7'h0E;
localparam logic [6:0] SEG7_BLANK = 7'h7F;
localparam logic [7:0] SEG7_AN_OFF = 8'hFF;
`endif

// File: rtl/seg7_hex_decoder.sv
// Purpose: 4-bit nibble to active-low 7-segment hex glyph.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of iNIB.
// Ports: iNIB  - nibble to show
//        oSEG  - segments {g,f,e,d,c,b,a}, active-low
module seg7_hex_decoder
  import seg7_reg32_display_pkg::*;
(
  input  logic [3:0] iNIB,
  output logic [6:0] oSEG
);

  always_comb begin
    oSEG = SEG7_BLANK;
    case (iNIB)
      4'h0: oSEG = SEG7_HEX_0;
      4'h1: oSEG = SEG7_HEX_1;
      4'h2: oSEG = SEG7_HEX_2;
      4'h3: oSEG = SEG7_HEX_3;
      4'h4: oSEG = SEG7_HEX_4;
      4'h5: oSEG = SEG7_HEX_5;
      4'h6: oSEG = SEG7_HEX_6;
      4'h7: oSEG = SEG7_HEX_7;
      4'h8: oSEG = SEG7_HEX_8;
      4'h9: oSEG = SEG7_HEX_9;
      4'hA: oSEG = SEG7_HEX_A;
      4'hB: oSEG = SEG7_HEX_B;
      4'hC: oSEG = SEG7_HEX_C;
      4'hD: oSEG = SEG7_HEX_D;
      4'hE: oSEG = SEG7_HEX_E;
      4'hF: oSEG = SEG7_HEX_F;
      default: oSEG = SEG7_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_reg32_display.sv
// Purpose: multiplexed 8-digit hex display of a 32-bit register, one coherent snapshot per frame.
// Latency: outputs registered, 1 cycle after a scan tick.
// Backpressure: none; iEN low blanks the display and freezes the scan.
// Ports: iCLK/iRST clock and sync active-high reset; iREG32 value to show;
//        iEN display enable; oAN active-low anodes (bit k = nibble k);
//        oSEG active-low segments {g,f,e,d,c,b,a}; oDP decimal point, always off.
module seg7_reg32_display
  import seg7_reg32_display_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b0
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iEN,
  input  logic [31:0] iREG32,
  output logic [7:0]  oAN,
  output logic [6:0]  oSEG,
  output logic        oDP
);

  localparam logic [15:0] PRESC_LAST = 16'(SCAN_DIV - 1);

  logic [15:0] presc_q, presc_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] shadow_q, shadow_d;
  logic [7:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;

  logic        tick;
  logic [2:0]  idx_nxt;
  logic [31:0] src;
  logic [3:0]  nib;
  logic [6:0]  dec_seg;
  logic        blank_lz;

  always_comb begin
    tick     = iEN && (presc_q == PRESC_LAST);
    idx_nxt  = idx_q + 3'd1;
    // Digit 0 reads the live register so the frame starts with the value
    // being captured into the shadow on that same edge.
    src      = (idx_nxt == 3'd0) ? iREG32 : shadow_q;
    nib      = src[{idx_nxt, 2'b00} +: 4];
    blank_lz = BLANK_LZ && (idx_nxt > msnz_idx(src));
  end

  seg7_hex_decoder u_dec (
    .iNIB (nib),
    .oSEG (dec_seg)
  );

  always_comb begin
    presc_d  = presc_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    an_d     = an_q;
    seg_d    = seg_q;
    if (!iEN) begin
      an_d  = SEG7_AN_OFF;
      seg_d = SEG7_BLANK;
    end else if (tick) begin
      presc_d = 16'd0;
      idx_d   = idx_nxt;
      an_d    = ~(8'd1 << idx_nxt);
      seg_d   = blank_lz ? SEG7_BLANK : dec_seg;
      if (idx_nxt == 3'd0) shadow_d = iREG32;
    end else begin
      presc_d = presc_q + 16'd1;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      presc_q  <= 16'd0;
      idx_q    <= 3'd7;
      shadow_q <= 32'h0;
      an_q     <= SEG7_AN_OFF;
      seg_q    <= SEG7_BLANK;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign oAN  = an_q;
  assign oSEG = seg_q;
  assign oDP  = 1'b1;

endmodule

// File: tb/tb_seg7_reg32_display.sv
module tb_seg7_reg32_display;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic        iEN  = 1'b0;
  logic [31:0] iREG32 = 32'h0;

  logic [7:0] an_a, an_b, an_c;
  logic [6:0] seg_a, seg_b, seg_c;
  logic       dp_a, dp_b, dp_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 iCLK = ~iCLK;

  seg7_reg32_display #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_a (
    .iCLK(iCLK), .iRST(iRST), .iEN(iEN), .iREG32(iREG32),
    .oAN(an_a), .oSEG(seg_a), .oDP(dp_a));

  seg7_reg32_display #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut_b (
    .iCLK(iCLK), .iRST(iRST), .iEN(iEN), .iREG32(iREG32),
    .oAN(an_b), .oSEG(seg_b), .oDP(dp_b));

  seg7_reg32_display #(.SCAN_DIV(1), .BLANK_LZ(1'b0)) dut_c (
    .iCLK(iCLK), .iRST(iRST), .iEN(iEN), .iREG32(iREG32),
    .oAN(an_c), .oSEG(seg_c), .oDP(dp_c));

  typedef struct {
    logic [31:0]     val;
    logic [7:0][6:0] seg_a;  // expected glyph per digit, no blanking
    logic [7:0][6:0] seg_b;  // expected glyph per digit, leading-zero blanking
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge iCLK);
    @(negedge iCLK);
  endtask

  // Leaves the bench at a negedge with reset just released and iEN=1.
  task automatic do_reset(input logic [31:0] val);
    @(negedge iCLK);
    iRST = 1'b1;
    iEN = 1'b1;
    iREG32 = val;
    repeat (2) @(posedge iCLK);
    @(negedge iCLK);
    iRST = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_an;
    logic [6:0] exp_c [10];

    //                     d7     d6     d5     d4     d3     d2     d1     d0
    vecs[0].val   = 32'h12345678;
    vecs[0].seg_a = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
    vecs[0].seg_b = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
    vecs[1].val   = 32'h000000A5;
    vecs[1].seg_a = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h12};
    vecs[1].seg_b = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h12};
    vecs[2].val   = 32'h00000000;
    vecs[2].seg_a = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    vecs[2].seg_b = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
    vecs[3].val   = 32'h0F00B0C1;
    vecs[3].seg_a = {7'h40, 7'h0E, 7'h40, 7'h40, 7'h03, 7'h40, 7'h46, 7'h79};
    vecs[3].seg_b = {7'h7F, 7'h0E, 7'h40, 7'h40, 7'h03, 7'h40, 7'h46, 7'h79};

    // Reset state and pre-tick blanking.
    do_reset(32'h12345678);
    check("reset an", an_a, 8'hFF);
    check("reset seg", seg_a, 7'h7F);
    check("reset dp", dp_a, 1'b1);
    cycles(3);
    check("pre-tick an", an_a, 8'hFF);

    // One full frame per vector; first tick lands 4 cycles after reset.
    for (int v = 0; v < 4; v++) begin
      do_reset(vecs[v].val);
      for (int k = 0; k < 8; k++) begin
        cycles(4);
        exp_an = ~(8'd1 << k);
        check($sformatf("v%0d d%0d an", v, k), an_a, exp_an);
        check($sformatf("v%0d d%0d seg", v, k), seg_a, vecs[v].seg_a[k]);
        check($sformatf("v%0d d%0d seg_lz", v, k), seg_b, vecs[v].seg_b[k]);
      end
    end

    // Mid-frame register change: digits 4..7 keep the snapshot.
    do_reset(32'hDEADBEEF);
    cycles(16);
    check("snap d3 an", an_a, 8'hF7);
    check("snap d3 seg", seg_a, 7'h03);
    iREG32 = 32'h0;
    cycles(4);
    check("snap d4 seg", seg_a, 7'h21);
    cycles(4);
    check("snap d5 seg", seg_a, 7'h08);
    cycles(4);
    check("snap d6 seg", seg_a, 7'h06);
    cycles(4);
    check("snap d7 seg", seg_a, 7'h21);
    for (int k = 0; k < 8; k++) begin
      cycles(4);
      check($sformatf("zero frame d%0d seg", k), seg_a, 7'h40);
    end

    // Enable dropped for 10 cycles after digit 2, one cycle into its slot.
    do_reset(32'h12345678);
    cycles(12);
    check("pre-drop an", an_a, 8'hFB);
    cycles(1);
    iEN = 1'b0;
    cycles(1);
    check("drop an", an_a, 8'hFF);
    check("drop seg", seg_a, 7'h7F);
    cycles(9);
    check("held an", an_a, 8'hFF);
    iEN = 1'b1;
    cycles(2);
    check("resume blank an", an_a, 8'hFF);
    cycles(1);
    check("resume an", an_a, 8'hF7);
    check("resume seg", seg_a, 7'h12);

    // Reset asserted on the same edge as a tick wins over the digit update.
    do_reset(32'h12345678);
    cycles(8);
    check("pre-rst an", an_a, 8'hFD);
    cycles(3);
    iRST = 1'b1;
    iREG32 = 32'h9ABCDEF0;
    cycles(1);
    check("rst-tick an", an_a, 8'hFF);
    check("rst-tick seg", seg_a, 7'h7F);
    iRST = 1'b0;
    cycles(3);
    check("post-rst blank an", an_a, 8'hFF);
    cycles(1);
    check("post-rst an", an_a, 8'hFE);
    check("post-rst seg", seg_a, 7'h40);

    // SCAN_DIV=1: a tick every enabled cycle, shadow reloads every 8.
    exp_c = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h79, 7'h24};
    do_reset(32'h12345678);
    for (int k = 0; k < 10; k++) begin
      cycles(1);
      exp_an = ~(8'd1 << (k % 8));
      check($sformatf("div1 c%0d an", k), an_c, exp_an);
      check($sformatf("div1 c%0d seg", k), seg_c, exp_c[k]);
      if (k == 3) iREG32 = 32'h87654321;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
